// File: rtl/eq_band_mixer_pkg.sv
// eq_pkg: shared constants and the controller state type for the equalizer
// band mixer (eq_band_mixer, eq_round_sat, eq_band_mixer_if).
package eq_pkg;

  localparam int unsigned DATA_W    = 24;  // band / output sample width, signed
  localparam int unsigned GAIN_W    = 16;  // gain width, signed Q2.14
  localparam int unsigned N_BANDS   = 10;  // 0 = lowpass .. 9 = highpass
  localparam int unsigned GAIN_FRAC = 14;  // fractional bits of the gain
  localparam int unsigned ACC_W     = 44;  // accumulator width, signed
  localparam int unsigned ADDR_W    = 4;   // band index width

  localparam logic signed [GAIN_W-1:0] UNITY_GAIN = 16'sd16384;
  localparam logic signed [DATA_W-1:0] OUT_MAX    = 24'sh7FFFFF;
  localparam logic signed [DATA_W-1:0] OUT_MIN    = 24'sh800000;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    SAT
  } state_t;

endpackage

// File: rtl/eq_band_mixer_if.sv
// eq_band_mixer_if: sample, gain-write and result signals of the band mixer.
//   master: filter-bank / control side (drives bands, strobe, gain writes)
//   slave : the mixer (drives audio_out, out_valid, busy, overrun)
interface eq_band_mixer_if;
  import eq_pkg::*;

  logic                     enable;
  logic                     sample_valid;
  logic signed [DATA_W-1:0] band_in_0;
  logic signed [DATA_W-1:0] band_in_1;
  logic signed [DATA_W-1:0] band_in_2;
  logic signed [DATA_W-1:0] band_in_3;
  logic signed [DATA_W-1:0] band_in_4;
  logic signed [DATA_W-1:0] band_in_5;
  logic signed [DATA_W-1:0] band_in_6;
  logic signed [DATA_W-1:0] band_in_7;
  logic signed [DATA_W-1:0] band_in_8;
  logic signed [DATA_W-1:0] band_in_9;
  logic                     gain_wr_en;
  logic [ADDR_W-1:0]        gain_addr;
  logic signed [GAIN_W-1:0] gain_data;
  logic signed [DATA_W-1:0] audio_out;
  logic                     out_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output enable, sample_valid,
    output band_in_0, band_in_1, band_in_2, band_in_3, band_in_4,
    output band_in_5, band_in_6, band_in_7, band_in_8, band_in_9,
    output gain_wr_en, gain_addr, gain_data,
    input  audio_out, out_valid, busy, overrun
  );

  modport slave (
    input  enable, sample_valid,
    input  band_in_0, band_in_1, band_in_2, band_in_3, band_in_4,
    input  band_in_5, band_in_6, band_in_7, band_in_8, band_in_9,
    input  gain_wr_en, gain_addr, gain_data,
    output audio_out, out_valid, busy, overrun
  );

endinterface

// File: rtl/eq_band_mixer_round_sat.sv
// eq_round_sat: converts the Q.14 accumulator to an output sample.
// Rounds half toward +inf (add 2^13, arithmetic shift by 14), then clamps
// to the signed 24-bit range.
//   acc      in  ACC_W   accumulated sum of band x gain products
//   sample_c out DATA_W  rounded, saturated sample (combinational)
module eq_round_sat
  import eq_pkg::*;
(
  input  logic signed [ACC_W-1:0]  acc,
  output logic signed [DATA_W-1:0] sample_c
);

  localparam logic signed [ACC_W-1:0] RND     = ACC_W'(1 << (GAIN_FRAC - 1));
  localparam logic signed [ACC_W-1:0] MAX_EXT = ACC_W'(OUT_MAX);
  localparam logic signed [ACC_W-1:0] MIN_EXT = ACC_W'(OUT_MIN);

  logic signed [ACC_W-1:0] rounded;
  logic signed [ACC_W-1:0] shifted;

  assign rounded = acc + RND;
  assign shifted = rounded >>> GAIN_FRAC;

  // Clamp to the 24-bit range
  always_comb begin
    sample_c = shifted[DATA_W-1:0];
    if (shifted > MAX_EXT) begin
      sample_c = OUT_MAX;
    end else if (shifted < MIN_EXT) begin
      sample_c = OUT_MIN;
    end
  end

endmodule

// File: rtl/eq_band_mixer.sv
// eq_band_mixer: recombines the ten filter-bank bands into one equalized
// sample. On an accepted strobe it snapshots the bands and gains, runs one
// shared multiply-accumulate per cycle over the ten bands, then rounds and
// saturates the sum. Result appears 12 cycles after the strobe.
//   clk, reset   clock and synchronous active-high reset
//   bus (slave)  enable, sample_valid, band_in_0..9, gain write port,
//                audio_out, out_valid, busy, overrun (all outputs registered)
module eq_band_mixer #(
  parameter int unsigned DATA_W  = eq_pkg::DATA_W,
  parameter int unsigned GAIN_W  = eq_pkg::GAIN_W,
  parameter int unsigned N_BANDS = eq_pkg::N_BANDS
) (
  input logic             clk,
  input logic             reset,
  eq_band_mixer_if.slave  bus
);
  import eq_pkg::*;

  localparam int unsigned          PROD_W   = DATA_W + GAIN_W;
  localparam logic [ADDR_W-1:0]    LAST_IDX = ADDR_W'(N_BANDS - 1);
  localparam logic [ADDR_W-1:0]    NB_ADDR  = ADDR_W'(N_BANDS);

  state_t                   state_q, state_d;
  logic                     accept_c;
  logic [ADDR_W-1:0]        idx_q;
  logic signed [ACC_W-1:0]  acc_q;
  logic signed [PROD_W-1:0] prod_c;
  logic signed [DATA_W-1:0] sat_c;
  logic signed [DATA_W-1:0] band_in_c   [N_BANDS];
  logic signed [DATA_W-1:0] band_q      [N_BANDS];
  logic signed [GAIN_W-1:0] gain_q      [N_BANDS];
  logic signed [GAIN_W-1:0] snap_gain_q [N_BANDS];

  // Band inputs gathered into an indexable array
  assign band_in_c[0] = bus.band_in_0;
  assign band_in_c[1] = bus.band_in_1;
  assign band_in_c[2] = bus.band_in_2;
  assign band_in_c[3] = bus.band_in_3;
  assign band_in_c[4] = bus.band_in_4;
  assign band_in_c[5] = bus.band_in_5;
  assign band_in_c[6] = bus.band_in_6;
  assign band_in_c[7] = bus.band_in_7;
  assign band_in_c[8] = bus.band_in_8;
  assign band_in_c[9] = bus.band_in_9;

  // Controller state register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Controller next state
  always_comb begin
    state_d  = state_q;
    accept_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.sample_valid && bus.enable) begin
          accept_c = 1'b1;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (idx_q == LAST_IDX) begin
          state_d = SAT;
        end
      end
      SAT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Shared multiplier: one band x gain product per ACCUM cycle
  assign prod_c = PROD_W'(band_q[idx_q]) * PROD_W'(snap_gain_q[idx_q]);

  eq_round_sat u_round_sat (
    .acc      (acc_q),
    .sample_c (sat_c)
  );

  // Datapath, gain register file and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q         <= '0;
      idx_q         <= '0;
      bus.audio_out <= '0;
      bus.out_valid <= 1'b0;
      bus.busy      <= 1'b0;
      bus.overrun   <= 1'b0;
      for (int i = 0; i < N_BANDS; i++) begin
        gain_q[i]      <= UNITY_GAIN;
        snap_gain_q[i] <= UNITY_GAIN;
        band_q[i]      <= '0;
      end
    end else begin
      bus.out_valid <= 1'b0;
      bus.busy      <= (state_d != IDLE);

      if (bus.gain_wr_en && (bus.gain_addr < NB_ADDR)) begin
        gain_q[bus.gain_addr] <= bus.gain_data;
      end

      // A strobe arriving while a sample is in flight is lost
      if (bus.sample_valid && bus.enable && (state_q != IDLE)) begin
        bus.overrun <= 1'b1;
      end

      // Snapshot reads gain_q before any same-cycle write lands
      if (accept_c) begin
        band_q      <= band_in_c;
        snap_gain_q <= gain_q;
        acc_q       <= '0;
        idx_q       <= '0;
      end

      if (state_q == ACCUM) begin
        acc_q <= acc_q + ACC_W'(prod_c);
        idx_q <= idx_q + ADDR_W'(1);
      end

      if (state_q == SAT) begin
        bus.audio_out <= sat_c;
        bus.out_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_eq_band_mixer.sv
// tb_eq_band_mixer: directed vectors with hand-computed results for the
// equalizer band mixer. Inputs change 1 time unit after the rising edge and
// outputs are sampled at that same point, away from the edge.
module tb_eq_band_mixer;
  import eq_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_errors = 0;

  always #10 clk = ~clk;

  eq_band_mixer_if bus ();

  eq_band_mixer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic check(input string tag, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_band(input int i, input int v);
    case (i)
      0: bus.band_in_0 = DATA_W'(v);
      1: bus.band_in_1 = DATA_W'(v);
      2: bus.band_in_2 = DATA_W'(v);
      3: bus.band_in_3 = DATA_W'(v);
      4: bus.band_in_4 = DATA_W'(v);
      5: bus.band_in_5 = DATA_W'(v);
      6: bus.band_in_6 = DATA_W'(v);
      7: bus.band_in_7 = DATA_W'(v);
      8: bus.band_in_8 = DATA_W'(v);
      default: bus.band_in_9 = DATA_W'(v);
    endcase
  endtask

  task automatic set_all(input int v);
    for (int i = 0; i < 10; i++) set_band(i, v);
  endtask

  task automatic write_gain(input int a, input int d);
    bus.gain_wr_en = 1'b1;
    bus.gain_addr  = ADDR_W'(a);
    bus.gain_data  = GAIN_W'(d);
    tick();
    bus.gain_wr_en = 1'b0;
  endtask

  // Strobe for one cycle; returns in cycle 1 relative to the strobe
  task automatic fire();
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    bus.gain_wr_en   = 1'b0;
  endtask

  // Called in cycle 1; waits for the result and checks value and timing
  task automatic wait_out(input string tag, input longint exp);
    int lat  = 0;
    bit seen = 1'b0;
    check({tag, "_busy1"}, longint'(bus.busy), 1);
    for (int c = 1; c <= 20; c++) begin
      if (bus.out_valid) begin
        seen = 1'b1;
        lat  = c;
        break;
      end
      tick();
    end
    check({tag, "_seen"}, longint'(seen), 1);
    check({tag, "_lat"}, longint'(lat), 12);
    check({tag, "_out"}, longint'(bus.audio_out), exp);
    check({tag, "_busy12"}, longint'(bus.busy), 0);
    tick();
    check({tag, "_pulse"}, longint'(bus.out_valid), 0);
  endtask

  initial begin
    int cnt;
    reset            = 1'b1;
    bus.enable       = 1'b1;
    bus.sample_valid = 1'b0;
    bus.gain_wr_en   = 1'b0;
    bus.gain_addr    = '0;
    bus.gain_data    = '0;
    set_all(0);
    tick();
    tick();
    reset = 1'b0;

    check("rst_audio", longint'(bus.audio_out), 0);
    check("rst_valid", longint'(bus.out_valid), 0);
    check("rst_busy", longint'(bus.busy), 0);
    check("rst_overrun", longint'(bus.overrun), 0);

    // Unity sum
    set_all(1000);
    fire();
    wait_out("unity", 10000);

    // Strobe ignored while disabled
    bus.enable = 1'b0;
    fire();
    check("dis_busy", longint'(bus.busy), 0);
    tick();
    check("dis_overrun", longint'(bus.overrun), 0);
    bus.enable = 1'b1;

    // Single band at half gain, including rounding of +/-1.5
    write_gain(3, 8192);
    set_all(0);
    set_band(3, 1000);
    fire();
    wait_out("b3_1000", 500);
    set_band(3, 3);
    fire();
    wait_out("b3_p3", 2);
    set_band(3, -3);
    fire();
    wait_out("b3_m3", -1);

    // Out-of-range address must not alias onto band 3
    write_gain(11, 0);
    set_band(3, 1000);
    fire();
    wait_out("addr_ign", 500);

    // Saturation at both rails
    for (int i = 0; i < 10; i++) write_gain(i, 32767);
    set_all(8388607);
    fire();
    wait_out("sat_pos", 8388607);
    set_all(-8388608);
    fire();
    wait_out("sat_neg", -8388608);

    reset = 1'b1;
    tick();
    reset = 1'b0;

    // Overrun: second strobe in cycle 5, then a strobe in cycle 12
    set_all(1000);
    fire();
    for (int i = 0; i < 4; i++) tick();
    set_all(0);
    bus.sample_valid = 1'b1;
    tick();
    bus.sample_valid = 1'b0;
    cnt = 0;
    for (int c = 6; c < 12; c++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    check("ov_early", longint'(cnt), 0);
    check("ov_valid12", longint'(bus.out_valid), 1);
    check("ov_out", longint'(bus.audio_out), 10000);
    check("ov_flag", longint'(bus.overrun), 1);
    set_all(2000);
    fire();
    wait_out("ov_accept", 20000);

    // Gain write in the same cycle as the strobe
    set_all(0);
    set_band(0, 1000);
    bus.gain_wr_en = 1'b1;
    bus.gain_addr  = '0;
    bus.gain_data  = '0;
    fire();
    wait_out("wr_same", 1000);
    fire();
    wait_out("wr_next", 0);

    // Reset mid-flight in cycle 6
    check("ov_sticky", longint'(bus.overrun), 1);
    set_all(1000);
    fire();
    for (int i = 0; i < 5; i++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("mid_busy", longint'(bus.busy), 0);
    check("mid_audio", longint'(bus.audio_out), 0);
    check("mid_overrun", longint'(bus.overrun), 0);
    cnt = 0;
    for (int i = 0; i < 15; i++) begin
      if (bus.out_valid) cnt++;
      tick();
    end
    check("mid_novalid", longint'(cnt), 0);
    fire();
    wait_out("post_rst", 10000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/eq_band_mixer.md
# eq_band_mixer

Recombination stage of the equalizer, consuming the ten band outputs of the FIR filter bank. On each sample strobe it snapshots all ten band samples, multiplies each by a programmable per-band gain with one time-multiplexed multiplier-accumulator, then rounds and saturates the sum to a 24-bit equalized output. It sits between the filter bank and the audio output path. A simple register-write port loads the gains.

## Interface
Parameters:
- `DATA_W`, 24: band and output sample width, signed.
- `GAIN_W`, 16: gain width, signed Q2.14.
- `N_BANDS`, 10: number of bands; index 0 = lowpass, 1..8 = 64–125 Hz .. 8k–16k, 9 = highpass.

Ports:
- `clk`  in  1  system clock, 50 MHz.
- `reset`  in  1  synchronous reset, active-high.
- `enable`  in  1  global enable; while low, `sample_valid` is ignored.
- `sample_valid`  in  1  one-cycle strobe; all band inputs are valid this cycle.
- `band_in_0` .. `band_in_9`  in  DATA_W each  band samples, in band-index order.
- `gain_wr_en`  in  1  gain register write strobe.
- `gain_addr`  in  4  band index for the write.
- `gain_data`  in  GAIN_W  gain value for the write.
- `audio_out`  out  DATA_W  equalized sample, registered.
- `out_valid`  out  1  one-cycle pulse when `audio_out` updates.
- `busy`  out  1  high while a sample is in flight.
- `overrun`  out  1  sticky flag, set when a strobe is dropped.

## Operation
- **States:** IDLE, ACCUM, SAT.
  - IDLE → ACCUM on `sample_valid & enable`. On that edge, snapshot the ten band inputs and all ten gains, clear the accumulator, set index = 0.
  - ACCUM: each cycle, acc += band[idx] × gain[idx]. Stay until idx = 9, then go to SAT.
  - SAT: acc + 2^13, arithmetic shift right by 14, clamp to [-8388608, 8388607]. Register the result into `audio_out` and pulse `out_valid`. Return to IDLE.
- **Arithmetic widths:** product 40 bits signed, accumulator 44 bits signed. No intermediate overflow is possible.
- **Rounding:** round half toward +∞; +1.5 → 2, -1.5 → -1.
- **Gains:**
  - Reset value of all gains is 16'sd16384 (unity).
  - Writes land in the register file immediately, but the in-flight sample uses its snapshot.
  - A write in the same cycle as an accepted strobe is not seen by that sample; the snapshot holds the old value.
  - Writes with `gain_addr` ≥ 10 are ignored.
- **Dropped strobes:** `sample_valid` while `busy` is dropped and sets `overrun`. Only `reset` clears `overrun`.
- **Disabled:** `enable` low does not abort an in-flight sample. `audio_out` holds its last value.
- **Reset mid-operation:** return to IDLE and discard the accumulator. `audio_out` = 0, `out_valid` = 0, `busy` = 0, `overrun` = 0, gains = unity.

## Timing
- Cycle 0: strobe accepted. `busy` is high in cycles 1–11, with ACCUM in cycles 1–10 and SAT in cycle 11.
- `audio_out` and `out_valid` are visible in cycle 12, and `busy` is low in cycle 12.
- Latency from strobe to `out_valid` is 12 cycles.
- A strobe in cycle 12 is accepted, so minimum spacing is 12 cycles. This is ample at 48 kHz.
- `out_valid` is high for exactly one cycle per accepted strobe.

## Structure
- **Package `eq_pkg`:**
  - Constants: DATA_W, GAIN_W, N_BANDS, GAIN_FRAC = 14, ACC_W = 44, UNITY_GAIN = 16'sd16384, OUT_MAX, OUT_MIN.
  - Typedef: state enum {IDLE, ACCUM, SAT}.
- **Sub-module `eq_round_sat`:** combinational, 44-bit accumulator in, 24-bit rounded and saturated sample out. Used in SAT.
- The multiplier is shared; there is one product per cycle.

## Test plan
- **Unity sum:** all gains unity, all bands = 1000, one strobe → `out_valid` in cycle 12, `audio_out` = 10000.
- **Single band:** gain[3] written to 8192, band 3 = 1000, others 0 → 500. With band 3 = 3 → 2; with band 3 = -3 → -1.
- **Saturation:** all gains = 32767.
  - All bands = 8388607 → 8388607.
  - All bands = -8388608 → -8388608.
- **Overrun:** strobe, then a second strobe in cycle 5 → exactly one `out_valid`, `overrun` = 1. A strobe in cycle 12 is accepted.
- **Write/strobe same cycle:** gain[0] written to 0 in the same cycle as a strobe, band 0 = 1000, others 0 → 1000. The next strobe → 0.
- **Reset mid-flight:** assert `reset` in cycle 6 → no `out_valid`, `audio_out` = 0, `busy` = 0, `overrun` = 0, gains back to unity. The next sample behaves as in the unity-sum case.
